l1c_victim_wb_buffer: RTL and testbench
=======================================

# l1c_victim_wb_buffer

Write-back victim buffer on the L1 data cache's memory side: it accepts dirty 64-byte lines evicted by the L1C and drains them in order as write-back requests toward the home node (HN). It also answers single-cycle-issue lookups from the L1C miss path so that a refill can be served from a victim line that has not yet been written back. It is the outbound (write-back) counterpart of the L1C refill path. Geometry matches the L1C configuration: 512-bit lines, 48-bit addresses, 6-bit line offset.

## Interface
- DATA_WIDTH, 512, line width in bits
- ADDR_WIDTH, 48, physical address width
- OFFSET, 6, line-offset bits; line address width LA = ADDR_WIDTH-OFFSET = 42
- VB_DEPTH, 16, number of entries; power of two, ≥2
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  synchronous, active-high reset
- evict_valid_i  in  1  eviction offered
- evict_ready_o  out  1  buffer can accept an eviction
- evict_addr_i  in  LA  line address of the victim
- evict_data_i  in  DATA_WIDTH  victim line data
- wb_req_valid_o  out  1  write-back request valid
- wb_req_ready_i  in  1  HN accepts the request
- wb_req_addr_o  out  LA  write-back line address
- wb_req_data_o  out  DATA_WIDTH  write-back data
- wb_ack_i  in  1  one-cycle pulse; in-order completion of the oldest issued request
- lookup_valid_i  in  1  lookup request
- lookup_addr_i  in  LA  line address to look up
- lookup_hit_o  out  1  registered lookup result
- lookup_data_o  out  DATA_WIDTH  data of the youngest matching entry; 0 on a miss
- count_o  out  $clog2(VB_DEPTH+1)  number of occupied entries
- ack_err_o  out  1  one-cycle pulse when an ack arrives with nothing outstanding

## Operation
- Entry states: FREE → PEND (allocated, not yet issued) → ISSUED (handshake done, awaiting ack) → FREE.
- Storage is a circular buffer with three pointers:
  - head: oldest non-free entry
  - iss: next PEND entry
  - tail: next allocation slot
- All pointers wrap modulo VB_DEPTH. Full and empty are tracked by an occupancy counter, not by pointer equality alone.
- evict_ready_o = (count_o != VB_DEPTH). It depends only on registered state and never on evict_addr_i.
- Eviction accepted (valid & ready):
  - If a PEND entry with the same address exists and is not locked, the data is overwritten in place (merge). No new entry is allocated and count is unchanged.
  - Otherwise a new PEND entry is allocated at tail.
- Locked entry: the entry at iss while wb_req_valid_o=1. It is never merged into, so request payload stays stable.
- wb_req_valid_o = (PEND entries exist). addr and data come from the entry at iss.
- On the valid & ready handshake, the entry becomes ISSUED and iss advances.
- wb_ack_i with ≥1 ISSUED entry frees the entry at head, head advances, and count decrements.
- wb_ack_i with 0 ISSUED entries is ignored and ack_err_o pulses. An ack in the same cycle as a handshake only retires requests already outstanding before that cycle.
- Same-cycle accept and ack on a full buffer: not possible, since ready is low when full. On a non-full buffer, count changes by +1−1 = 0.
- Lookup:
  - Compares against all non-FREE entries (PEND and ISSUED) as they are at the start of the cycle.
  - A same-cycle eviction is not visible; an entry freed by a same-cycle ack still hits.
  - If several entries match, the youngest (closest to tail) wins.

## Timing
- Reset values:
  - All pointers and count_o = 0; all entries FREE.
  - evict_ready_o = 1 from the first cycle after reset.
  - wb_req_valid_o, lookup_hit_o, ack_err_o = 0.
  - wb_req_addr_o, wb_req_data_o, lookup_data_o = 0.
- Reset mid-operation discards all entries, including ISSUED ones. Acks arriving after reset raise ack_err_o.
- Latency:
  - An accepted eviction into an empty buffer gives wb_req_valid_o=1 on the next cycle.
  - Back-to-back handshakes are sustainable at one per cycle.
- Once wb_req_valid_o is high, it stays high with stable addr/data until wb_req_ready_i (AXI-style rule).
- Lookup latency is exactly 1 cycle: lookup_hit_o and lookup_data_o are valid the cycle after lookup_valid_i. When lookup_valid_i=0, lookup_hit_o=0 the next cycle.
- count_o and evict_ready_o update the cycle after the event that changes them.

## Test plan
- Reset, then evict A=0x1 with data D1: next cycle wb_req_valid_o=1, addr 0x1, data D1. Handshake, then ack 3 cycles later: count_o goes 1,1,…,0; no ack_err_o.
- Hold wb_req_ready_i=0 and fill 16 distinct evictions: evict_ready_o=0 when count_o=16. Then drain with ready=1: 16 in-order requests. Ack all: count_o=0, evict_ready_o=1.
- Merge case, with wb_req_ready_i=0: evict 0x5/D1, then 0x7/D2, then 0x7/D3. Result: count_o=2 and 0x7 is issued with D3. Repeating the same sequence with 0x5 as the second address: 0x5 is locked, so count_o=3.
- Lookup case: entry 0x9 is ISSUED with D1 and 0x9 is PEND with D2. A lookup of 0x9 gives hit=1, data D2 the next cycle. A lookup of 0xA gives hit=0, data 0.
- wb_ack_i with no outstanding request: ack_err_o pulses for 1 cycle and state is unchanged. Ack in the same cycle as the first handshake on an empty-outstanding buffer: ack_err_o=1 and the entry stays ISSUED.
- Assert rst_i with 3 ISSUED and 2 PEND entries: next cycle count_o=0, wb_req_valid_o=0; a subsequent ack gives ack_err_o=1.

Source files
------------

// File: rtl/l1c_victim_wb_buffer.sv
// Write-back victim buffer: queues dirty L1C victims, drains them in order to HN, merges into un-issued lines.
// Lookup result is registered (1 cycle); evict_ready_o drops only when every entry holds a line.
module l1c_victim_wb_buffer #(
  parameter  int DATA_WIDTH = 512,
  parameter  int ADDR_WIDTH = 48,
  parameter  int OFFSET     = 6,
  parameter  int VB_DEPTH   = 16,
  localparam int LA         = ADDR_WIDTH - OFFSET,
  localparam int PW         = $clog2(VB_DEPTH),
  localparam int CW         = $clog2(VB_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  evict_valid_i,
  output logic                  evict_ready_o,
  input  logic [LA-1:0]         evict_addr_i,
  input  logic [DATA_WIDTH-1:0] evict_data_i,
  output logic                  wb_req_valid_o,
  input  logic                  wb_req_ready_i,
  output logic [LA-1:0]         wb_req_addr_o,
  output logic [DATA_WIDTH-1:0] wb_req_data_o,
  input  logic                  wb_ack_i,
  input  logic                  lookup_valid_i,
  input  logic [LA-1:0]         lookup_addr_i,
  output logic                  lookup_hit_o,
  output logic [DATA_WIDTH-1:0] lookup_data_o,
  output logic [CW-1:0]         count_o,
  output logic                  ack_err_o
);

  typedef logic [PW-1:0] ptr_t;

  logic [LA-1:0]         addr_mem [VB_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [VB_DEPTH];

  // The oldest entry sits at tail - count_o; the ISSUED run precedes iss, the PEND run follows it.
  ptr_t          tail;
  ptr_t          iss;
  logic [CW-1:0] pend_cnt;
  logic [CW-1:0] issued_cnt;

  ptr_t age_idx [VB_DEPTH];

  logic evict_fire;
  logic wb_fire;
  logic ack_ok;
  logic alloc;
  logic merge_hit;
  ptr_t merge_idx;
  logic lk_hit;
  ptr_t lk_idx;

  assign issued_cnt     = count_o - pend_cnt;
  assign evict_ready_o  = (count_o != CW'(VB_DEPTH));
  assign wb_req_valid_o = (pend_cnt != '0);
  assign wb_req_addr_o  = wb_req_valid_o ? addr_mem[iss] : '0;
  assign wb_req_data_o  = wb_req_valid_o ? data_mem[iss] : '0;

  assign evict_fire = evict_valid_i & evict_ready_o;
  assign wb_fire    = wb_req_valid_o & wb_req_ready_i;
  assign ack_ok     = wb_ack_i & (issued_cnt != '0);
  assign alloc      = evict_fire & ~merge_hit;

  // age 0 is the youngest entry (just behind tail)
  always_comb begin
    for (int k = 0; k < VB_DEPTH; k++) begin
      age_idx[k] = tail - ptr_t'(k + 1);
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  // The oldest PEND entry (age pend_cnt-1) is the one being presented, so it is excluded from merges.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    lk_hit    = 1'b0;
    lk_idx    = '0;
    for (int k = VB_DEPTH - 1; k >= 0; k--) begin
      if ((CW'(k + 1) < pend_cnt) && (addr_mem[age_idx[k]] == evict_addr_i)) begin
        merge_hit = 1'b1;
        merge_idx = age_idx[k];
      end
      if ((CW'(k) < count_o) && (addr_mem[age_idx[k]] == lookup_addr_i)) begin
        lk_hit = 1'b1;
        lk_idx = age_idx[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && evict_fire) begin
      if (merge_hit) begin
        data_mem[merge_idx] <= evict_data_i;
      end else begin
        addr_mem[tail] <= evict_addr_i;
        data_mem[tail] <= evict_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tail          <= '0;
      iss           <= '0;
      count_o       <= '0;
      pend_cnt      <= '0;
      ack_err_o     <= 1'b0;
      lookup_hit_o  <= 1'b0;
      lookup_data_o <= '0;
    end else begin
      if (alloc) begin
        tail <= tail + ptr_t'(1);
      end
      if (wb_fire) begin
        iss <= iss + ptr_t'(1);
      end
      count_o       <= count_o + CW'(alloc) - CW'(ack_ok);
      pend_cnt      <= pend_cnt + CW'(alloc) - CW'(wb_fire);
      ack_err_o     <= wb_ack_i & ~ack_ok;
      lookup_hit_o  <= lookup_valid_i & lk_hit;
      lookup_data_o <= (lookup_valid_i & lk_hit) ? data_mem[lk_idx] : '0;
    end
  end

  a_pend_le_count: assert property (@(posedge clk_i) disable iff (rst_i) pend_cnt <= count_o);
  a_count_bound:   assert property (@(posedge clk_i) disable iff (rst_i) count_o <= CW'(VB_DEPTH));
  a_req_stable:    assert property (@(posedge clk_i) disable iff (rst_i)
                     (wb_req_valid_o && !wb_req_ready_i) |=>
                     (wb_req_valid_o && $stable(wb_req_addr_o) && $stable(wb_req_data_o)));

endmodule

// File: tb/tb_l1c_victim_wb_buffer.sv
// Randomized + directed bench for l1c_victim_wb_buffer against a queue-based reference model.
module tb_l1c_victim_wb_buffer;
  localparam int DW = 512;
  localparam int LA = 42;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          evict_valid;
  logic          evict_ready;
  logic [LA-1:0] evict_addr;
  logic [DW-1:0] evict_data;
  logic          wb_valid;
  logic          wb_ready;
  logic [LA-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ack;
  logic          lookup_valid;
  logic [LA-1:0] lookup_addr;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic [CW-1:0] count;
  logic          ack_err;

  always #5 clk = ~clk;

  l1c_victim_wb_buffer dut (
    .clk_i(clk), .rst_i(rst),
    .evict_valid_i(evict_valid), .evict_ready_o(evict_ready),
    .evict_addr_i(evict_addr), .evict_data_i(evict_data),
    .wb_req_valid_o(wb_valid), .wb_req_ready_i(wb_ready),
    .wb_req_addr_o(wb_addr), .wb_req_data_o(wb_data),
    .wb_ack_i(wb_ack),
    .lookup_valid_i(lookup_valid), .lookup_addr_i(lookup_addr),
    .lookup_hit_o(lookup_hit), .lookup_data_o(lookup_data),
    .count_o(count), .ack_err_o(ack_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: oldest-first queue; entries [0, m_iss) are ISSUED, the rest PEND.
  logic [LA-1:0] m_addr [$];
  logic [DW-1:0] m_data [$];
  int            m_iss     = 0;
  bit            e_lk_hit  = 1'b0;
  logic [DW-1:0] e_lk_data = '0;
  bit            e_err     = 1'b0;
  bit            mv_hit, mv_vld, mv_rdy, mv_ack;
  logic [DW-1:0] mv_d;
  int            mj;

  always @(posedge clk) begin
    if (rst) begin
      m_addr.delete();
      m_data.delete();
      m_iss     = 0;
      e_lk_hit  = 1'b0;
      e_lk_data = '0;
      e_err     = 1'b0;
    end else begin
      mv_hit = 1'b0;
      mv_d   = '0;
      foreach (m_addr[i]) begin
        if (m_addr[i] == lookup_addr) begin
          mv_hit = 1'b1;
          mv_d   = m_data[i];
        end
      end
      e_lk_hit  = lookup_valid && mv_hit;
      e_lk_data = e_lk_hit ? mv_d : '0;
      mv_vld = m_addr.size() > m_iss;
      mv_rdy = m_addr.size() != D;
      mv_ack = wb_ack && (m_iss > 0);
      e_err  = wb_ack && (m_iss == 0);
      if (evict_valid && mv_rdy) begin
        mj = -1;
        for (int j = m_iss + 1; j < m_addr.size(); j++) begin
          if (m_addr[j] == evict_addr) mj = j;
        end
        if (mj >= 0) begin
          m_data[mj] = evict_data;
        end else begin
          m_addr.push_back(evict_addr);
          m_data.push_back(evict_data);
        end
      end
      if (mv_vld && wb_ready) m_iss++;
      if (mv_ack) begin
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
        m_iss--;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_count", DW'(count), DW'(m_addr.size()));
      chk("cmp_evict_ready", DW'(evict_ready), DW'(m_addr.size() != D));
      chk("cmp_wb_valid", DW'(wb_valid), DW'(m_addr.size() > m_iss));
      chk("cmp_wb_addr", DW'(wb_addr), (m_addr.size() > m_iss) ? DW'(m_addr[m_iss]) : '0);
      chk("cmp_wb_data", wb_data, (m_addr.size() > m_iss) ? m_data[m_iss] : '0);
      chk("cmp_lookup_hit", DW'(lookup_hit), DW'(e_lk_hit));
      chk("cmp_lookup_data", lookup_data, e_lk_data);
      chk("cmp_ack_err", DW'(ack_err), DW'(e_err));
    end
  end

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    evict_valid  = 1'b0;
    evict_addr   = '0;
    evict_data   = '0;
    wb_ready     = 1'b0;
    wb_ack       = 1'b0;
    lookup_valid = 1'b0;
    lookup_addr  = '0;
  endtask

  task automatic evict(input logic [LA-1:0] a, input logic [DW-1:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic acks(input int n);
    wb_ack = 1'b1;
    repeat (n) tick();
    wb_ack = 1'b0;
  endtask

  logic [DW-1:0] d1, d2, d3;
  logic [DW-1:0] fill_d [D];
  int            phase;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("reset_count", DW'(count), DW'(0));
    chk("reset_evict_ready", DW'(evict_ready), DW'(1));
    chk("reset_wb_valid", DW'(wb_valid), DW'(0));
    chk("reset_wb_data", wb_data, '0);
    chk("reset_lookup_hit", DW'(lookup_hit), DW'(0));
    chk("reset_ack_err", DW'(ack_err), DW'(0));

    // single eviction, handshake, ack
    d1 = rand_line();
    evict(42'h1, d1);
    chk("first_valid", DW'(wb_valid), DW'(1));
    chk("first_addr", DW'(wb_addr), DW'(42'h1));
    chk("first_data", wb_data, d1);
    chk("first_count", DW'(count), DW'(1));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("issued_valid", DW'(wb_valid), DW'(0));
    chk("issued_count", DW'(count), DW'(1));
    tick();
    tick();
    acks(1);
    chk("acked_count", DW'(count), DW'(0));
    chk("acked_err", DW'(ack_err), DW'(0));

    // fill to capacity, then drain in order
    for (int i = 0; i < D; i++) begin
      fill_d[i] = rand_line();
      evict(LA'(32'h100 + i), fill_d[i]);
    end
    chk("full_count", DW'(count), DW'(16));
    chk("full_ready", DW'(evict_ready), DW'(0));
    wb_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("drain_addr", DW'(wb_addr), DW'(LA'(32'h100 + i)));
      chk("drain_data", wb_data, fill_d[i]);
      tick();
    end
    wb_ready = 1'b0;
    chk("drained_valid", DW'(wb_valid), DW'(0));
    acks(D);
    chk("empty_count", DW'(count), DW'(0));
    chk("empty_ready", DW'(evict_ready), DW'(1));

    // merge into an unlocked PEND entry
    d1 = rand_line(); d2 = rand_line(); d3 = rand_line();
    evict(42'h5, d1);
    evict(42'h7, d2);
    evict(42'h7, d3);
    chk("merge_count", DW'(count), DW'(2));
    wb_ready = 1'b1;
    chk("merge_req0_addr", DW'(wb_addr), DW'(42'h5));
    tick();
    chk("merge_req1_addr", DW'(wb_addr), DW'(42'h7));
    chk("merge_req1_data", wb_data, d3);
    tick();
    wb_ready = 1'b0;
    acks(2);

    // same address as the presented (locked) entry must allocate
    evict(42'h5, d1);
    evict(42'h7, d2);
    evict(42'h5, d3);
    chk("locked_count", DW'(count), DW'(3));
    chk("locked_data", wb_data, d1);
    wb_ready = 1'b1;
    repeat (2) tick();
    chk("locked_req2_addr", DW'(wb_addr), DW'(42'h5));
    chk("locked_req2_data", wb_data, d3);
    tick();
    wb_ready = 1'b0;
    acks(3);

    // lookup: youngest match among ISSUED + PEND
    evict(42'h9, d1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    evict(42'h9, d2);
    lookup_valid = 1'b1;
    lookup_addr  = 42'h9;
    tick();
    chk("lookup_hit", DW'(lookup_hit), DW'(1));
    chk("lookup_data", lookup_data, d2);
    lookup_addr = 42'hA;
    tick();
    chk("lookup_miss_hit", DW'(lookup_hit), DW'(0));
    chk("lookup_miss_data", lookup_data, '0);
    lookup_valid = 1'b0;
    lookup_addr  = 42'h9;
    tick();
    chk("lookup_idle_hit", DW'(lookup_hit), DW'(0));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    acks(2);

    // spurious acks
    acks(1);
    chk("spurious_err", DW'(ack_err), DW'(1));
    chk("spurious_count", DW'(count), DW'(0));
    tick();
    chk("spurious_err_clear", DW'(ack_err), DW'(0));
    evict(42'h33, d1);
    wb_ready = 1'b1;
    wb_ack   = 1'b1;
    tick();
    wb_ready = 1'b0;
    wb_ack   = 1'b0;
    chk("hs_ack_err", DW'(ack_err), DW'(1));
    chk("hs_ack_count", DW'(count), DW'(1));
    acks(1);
    chk("hs_ack_retired", DW'(count), DW'(0));
    chk("hs_ack_noerr", DW'(ack_err), DW'(0));

    // reset with 3 ISSUED and 2 PEND entries
    for (int i = 0; i < 5; i++) evict(LA'(32'h20 + i), rand_line());
    wb_ready = 1'b1;
    repeat (3) tick();
    wb_ready = 1'b0;
    chk("prerst_count", DW'(count), DW'(5));
    chk("prerst_addr", DW'(wb_addr), DW'(42'h23));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_valid", DW'(wb_valid), DW'(0));
    acks(1);
    chk("rst_ack_err", DW'(ack_err), DW'(1));

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      phase        = (c / 400) % 2;
      evict_valid  = 1'($urandom_range(0, 1));
      evict_addr   = LA'((phase == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5));
      evict_data   = rand_line();
      wb_ready     = (phase == 0) ? ($urandom_range(0, 7) < 2) : ($urandom_range(0, 7) < 6);
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_addr  = LA'($urandom_range(0, 7));
      if (m_iss > 0) wb_ack = (phase == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      else           wb_ack = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle();
    rst = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
